// File: rtl/shift_ex_stage.sv
// shift_ex_stage: two-entry pipelined execute wrapper around an external
// combinational Shifter. S1 registers the accepted operands and drives the
// Shifter; S2 captures Shift_Out for writeback. Flush clears both stages,
// illegal opcodes are consumed and latch a sticky error flag, and completed
// transfers are counted with a saturating counter.
// Optional build macro: SHIFT_ZFLAG_EN adds out_z (zero result alongside
// out_data) and flag_z (zero flag updated on each output transfer).

module shift_ex_stage #(
   parameter int DW    = 16,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_opcode,
   input  logic [DW-1:0]    in_src,
   input  logic [3:0]       in_imm,
   input  logic [3:0]       in_rd,
   output logic [DW-1:0]    sh_in,
   output logic [3:0]       sh_val,
   output logic             sh_mode,
   input  logic [DW-1:0]    sh_out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [DW-1:0]    out_data,
   output logic [3:0]       out_rd,
   output logic             err,
   output logic [CNT_W-1:0] op_count
`ifdef SHIFT_ZFLAG_EN
   ,
   output logic             out_z,
   output logic             flag_z
`endif
);

   localparam logic [3:0] OP_SLL = 4'b0100;
   localparam logic [3:0] OP_SRA = 4'b0101;

   logic             s1_valid_q, s1_valid_d;
   logic [DW-1:0]    s1_src_q, s1_src_d;
   logic [3:0]       s1_imm_q, s1_imm_d;
   logic [3:0]       s1_rd_q, s1_rd_d;
   logic             s1_mode_q, s1_mode_d;
   logic             s2_valid_q, s2_valid_d;
   logic [DW-1:0]    out_data_q, out_data_d;
   logic [3:0]       out_rd_q, out_rd_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] op_count_q, op_count_d;
`ifdef SHIFT_ZFLAG_EN
   logic             out_z_q, out_z_d;
   logic             flag_z_q, flag_z_d;
`endif

   logic s1_adv;
   logic accept;
   logic legal;
   logic xfer;

   // Handshake: S1 may hand off when S2 is empty or draining this cycle.
   always_comb begin
      s1_adv   = s1_valid_q && (!s2_valid_q || out_ready);
      in_ready = !flush && (!s1_valid_q || s1_adv);
      accept   = in_valid && in_ready;
      legal    = (in_opcode == OP_SLL) || (in_opcode == OP_SRA);
      xfer     = s2_valid_q && out_ready;
   end

   // Next-state for both stages, error flag and completion counter.
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_src_d   = s1_src_q;
      s1_imm_d   = s1_imm_q;
      s1_rd_d    = s1_rd_q;
      s1_mode_d  = s1_mode_q;
      s2_valid_d = s2_valid_q;
      out_data_d = out_data_q;
      out_rd_d   = out_rd_q;
      err_d      = err_q;
      op_count_d = op_count_q;
`ifdef SHIFT_ZFLAG_EN
      out_z_d    = out_z_q;
      flag_z_d   = flag_z_q;
`endif

      if (flush) begin
         s1_valid_d = 1'b0;
         s2_valid_d = 1'b0;
      end else begin
         if (accept && legal) begin
            s1_valid_d = 1'b1;
            s1_src_d   = in_src;
            s1_imm_d   = in_imm;
            s1_rd_d    = in_rd;
            s1_mode_d  = in_opcode[0];
         end else if (s1_adv) begin
            s1_valid_d = 1'b0;
         end

         if (s1_adv) begin
            s2_valid_d = 1'b1;
            out_data_d = sh_out;
            out_rd_d   = s1_rd_q;
`ifdef SHIFT_ZFLAG_EN
            out_z_d    = (sh_out == '0);
`endif
         end else if (xfer) begin
            s2_valid_d = 1'b0;
         end
      end

      // Illegal ops complete the handshake but only leave the sticky flag behind.
      if (accept && !legal) begin
         err_d = 1'b1;
      end

      // A transfer that coincides with flush still reached writeback, so it counts.
      if (xfer) begin
         if (op_count_q != '1) begin
            op_count_d = op_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
         end
`ifdef SHIFT_ZFLAG_EN
         flag_z_d = out_z_q;
`endif
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_src_q   <= '0;
         s1_imm_q   <= '0;
         s1_rd_q    <= '0;
         s1_mode_q  <= 1'b0;
         s2_valid_q <= 1'b0;
         out_data_q <= '0;
         out_rd_q   <= '0;
         err_q      <= 1'b0;
         op_count_q <= '0;
`ifdef SHIFT_ZFLAG_EN
         out_z_q    <= 1'b0;
         flag_z_q   <= 1'b0;
`endif
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_src_q   <= s1_src_d;
         s1_imm_q   <= s1_imm_d;
         s1_rd_q    <= s1_rd_d;
         s1_mode_q  <= s1_mode_d;
         s2_valid_q <= s2_valid_d;
         out_data_q <= out_data_d;
         out_rd_q   <= out_rd_d;
         err_q      <= err_d;
         op_count_q <= op_count_d;
`ifdef SHIFT_ZFLAG_EN
         out_z_q    <= out_z_d;
         flag_z_q   <= flag_z_d;
`endif
      end
   end

   // Shifter is driven straight from the S1 registers.
   always_comb begin
      sh_in     = s1_src_q;
      sh_val    = s1_imm_q;
      sh_mode   = s1_mode_q;
      out_valid = s2_valid_q;
      out_data  = out_data_q;
      out_rd    = out_rd_q;
      err       = err_q;
      op_count  = op_count_q;
`ifdef SHIFT_ZFLAG_EN
      out_z     = out_z_q;
      flag_z    = flag_z_q;
`endif
   end

endmodule

// File: tb/tb_shift_ex_stage.sv
// Bench for shift_ex_stage. Models the external Shifter combinationally,
// keeps a scoreboard of expected results pushed on accept and popped on
// output transfer, and runs one task per scenario.
// Optional build macro: SHIFT_ZFLAG_EN enables the zero-flag scenario.

module tb_shift_ex_stage;

   localparam int DW    = 16;
   localparam int CNT_W = 4;

   logic             clk;
   logic             rst_n;
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       in_opcode;
   logic [DW-1:0]    in_src;
   logic [3:0]       in_imm;
   logic [3:0]       in_rd;
   logic [DW-1:0]    sh_in;
   logic [3:0]       sh_val;
   logic             sh_mode;
   logic [DW-1:0]    sh_out;
   logic             out_valid;
   logic             out_ready;
   logic [DW-1:0]    out_data;
   logic [3:0]       out_rd;
   logic             err;
   logic [CNT_W-1:0] op_count;
`ifdef SHIFT_ZFLAG_EN
   logic             out_z;
   logic             flag_z;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [DW-1:0] data;
      logic [3:0]    rd;
   } exp_t;

   exp_t exp_q[$];
   int   model_cnt = 0;

   shift_ex_stage #(.DW(DW), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_opcode (in_opcode),
      .in_src    (in_src),
      .in_imm    (in_imm),
      .in_rd     (in_rd),
      .sh_in     (sh_in),
      .sh_val    (sh_val),
      .sh_mode   (sh_mode),
      .sh_out    (sh_out),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_rd    (out_rd),
      .err       (err),
      .op_count  (op_count)
`ifdef SHIFT_ZFLAG_EN
      ,
      .out_z     (out_z),
      .flag_z    (flag_z)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [DW-1:0] shift_model(input logic [DW-1:0] v,
                                                 input logic [3:0] amt,
                                                 input logic mode);
      logic signed [DW-1:0] s;
      s = v;
      if (mode) return DW'(s >>> amt);
      return v << amt;
   endfunction

   // External Shifter stand-in.
   always_comb sh_out = shift_model(sh_in, sh_val, sh_mode);

   // Scoreboard monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         model_cnt = 0;
      end else begin
         if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL sb_unexpected: got data=%h rd=%0d, expected no output", out_data, out_rd);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               if (out_data !== e.data || out_rd !== e.rd) begin
                  errors++;
                  $display("FAIL sb_result: got data=%h rd=%0d, expected data=%h rd=%0d",
                           out_data, out_rd, e.data, e.rd);
               end
            end
            if (model_cnt < (1 << CNT_W) - 1) model_cnt++;
         end
         if (flush) exp_q.delete();
         if (in_valid && in_ready && (in_opcode == 4'b0100 || in_opcode == 4'b0101)) begin
            exp_t n;
            n.data = shift_model(in_src, in_imm, in_opcode[0]);
            n.rd   = in_rd;
            exp_q.push_back(n);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_op(input logic [3:0] op, input logic [DW-1:0] src,
                          input logic [3:0] imm, input logic [3:0] rd);
      bit done;
      done      = 0;
      in_valid  = 1'b1;
      in_opcode = op;
      in_src    = src;
      in_imm    = imm;
      in_rd     = rd;
      for (int i = 0; i < 20 && !done; i++) begin
         #1;
         if (in_ready) done = 1;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: in_ready stayed 0, expected 1 within 20 cycles");
      end
   endtask

   task automatic drain();
      bit done;
      done = 0;
      for (int i = 0; i < 30 && !done; i++) begin
         if (exp_q.size() == 0 && !out_valid) done = 1;
         else tick();
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: %0d results pending, expected 0", exp_q.size());
      end
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_opcode = '0;
      in_src    = '0;
      in_imm    = '0;
      in_rd     = '0;
      out_ready = 1'b1;
      tick();
      tick();
      checks++;
      if (out_valid !== 1'b0 || err !== 1'b0 || op_count !== '0) begin
         errors++;
         $display("FAIL reset_status: got out_valid=%b err=%b op_count=%0d, expected 0 0 0",
                  out_valid, err, op_count);
      end
      checks++;
      if (sh_in !== '0 || sh_val !== '0 || sh_mode !== 1'b0 || out_data !== '0 || out_rd !== '0) begin
         errors++;
         $display("FAIL reset_regs: got sh_in=%h sh_val=%0d sh_mode=%b out_data=%h out_rd=%0d, expected all 0",
                  sh_in, sh_val, sh_mode, out_data, out_rd);
      end
      rst_n = 1'b1;
      tick();
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready: got in_ready=%b, expected 1", in_ready);
      end
   endtask

   task automatic test_sll_latency();
      out_ready = 1'b1;
      send_op(4'b0100, 16'h0001, 4'd4, 4'd3);
      checks++;
      if (sh_in !== 16'h0001 || sh_val !== 4'd4 || sh_mode !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL sll_s1: got sh_in=%h sh_val=%0d sh_mode=%b out_valid=%b, expected 0001 4 0 0",
                  sh_in, sh_val, sh_mode, out_valid);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'h0010 || out_rd !== 4'd3) begin
         errors++;
         $display("FAIL sll_result: got valid=%b data=%h rd=%0d, expected 1 0010 3",
                  out_valid, out_data, out_rd);
      end
      tick();
      checks++;
      if (op_count !== 4'd1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL sll_count: got op_count=%0d out_valid=%b, expected 1 0", op_count, out_valid);
      end
   endtask

   task automatic test_sra();
      out_ready = 1'b1;
      send_op(4'b0101, 16'h8000, 4'd15, 4'd5);
      send_op(4'b0101, 16'h7FF0, 4'd4, 4'd6);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'hFFFF || out_rd !== 4'd5) begin
         errors++;
         $display("FAIL sra_neg: got valid=%b data=%h rd=%0d, expected 1 ffff 5", out_valid, out_data, out_rd);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'h07FF || out_rd !== 4'd6) begin
         errors++;
         $display("FAIL sra_pos: got valid=%b data=%h rd=%0d, expected 1 07ff 6", out_valid, out_data, out_rd);
      end
      drain();
      checks++;
      if (op_count !== 4'd3) begin
         errors++;
         $display("FAIL sra_count: got op_count=%0d, expected 3", op_count);
      end
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] srcs [4] = '{16'h1234, 16'h0F0F, 16'hA5A5, 16'h8001};
      logic [3:0]    imms [4] = '{4'd1, 4'd3, 4'd7, 4'd2};
      logic [3:0]    ops  [4] = '{4'b0100, 4'b0101, 4'b0100, 4'b0101};
      int            idx;
      int            stall_left;
      int            start_cnt;
      logic [DW-1:0] held_sh;
      bit            acc;
      idx        = 0;
      stall_left = -1;
      start_cnt  = model_cnt;
      held_sh    = '0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         if (idx == 4 && exp_q.size() == 0 && !out_valid) break;
         if (stall_left < 0 && out_valid) begin
            stall_left = 3;
            held_sh    = sh_in;
         end
         out_ready = (stall_left > 0) ? 1'b0 : 1'b1;
         in_valid  = (idx < 4);
         if (idx < 4) begin
            in_opcode = ops[idx];
            in_src    = srcs[idx];
            in_imm    = imms[idx];
            in_rd     = 4'(idx + 8);
         end
         #1;
         if (stall_left > 0) begin
            checks++;
            if (in_ready !== 1'b0 || sh_in !== held_sh) begin
               errors++;
               $display("FAIL b2b_stall: got in_ready=%b sh_in=%h, expected 0 %h", in_ready, sh_in, held_sh);
            end
            stall_left--;
         end
         acc = in_valid && in_ready;
         @(posedge clk);
         #1;
         if (acc) idx++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      drain();
      checks++;
      if (idx != 4 || op_count !== 4'(start_cnt + 4)) begin
         errors++;
         $display("FAIL b2b_count: got accepted=%0d op_count=%0d, expected 4 %0d", idx, op_count, start_cnt + 4);
      end
   endtask

   task automatic test_illegal();
      out_ready = 1'b1;
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("FAIL illegal_pre: got err=%b, expected 0", err);
      end
      send_op(4'b0000, 16'hDEAD, 4'd2, 4'd9);
      checks++;
      if (err !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL illegal_err: got err=%b out_valid=%b, expected 1 0", err, out_valid);
      end
      tick();
      tick();
      checks++;
      if (out_valid !== 1'b0 || err !== 1'b1) begin
         errors++;
         $display("FAIL illegal_noout: got out_valid=%b err=%b, expected 0 1", out_valid, err);
      end
      send_op(4'b0100, 16'h0003, 4'd1, 4'd7);
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'h0006 || out_rd !== 4'd7) begin
         errors++;
         $display("FAIL illegal_next: got valid=%b data=%h rd=%0d, expected 1 0006 7", out_valid, out_data, out_rd);
      end
      drain();
   endtask

   task automatic test_flush();
      logic [CNT_W-1:0] cnt_before;
      out_ready = 1'b0;
      send_op(4'b0100, 16'h0101, 4'd1, 4'd1);
      send_op(4'b0101, 16'h0202, 4'd1, 4'd2);
      cnt_before = op_count;
      flush     = 1'b1;
      in_valid  = 1'b1;
      in_opcode = 4'b0100;
      in_src    = 16'h0303;
      in_imm    = 4'd1;
      in_rd     = 4'd4;
      #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL flush_ready: got in_ready=%b out_valid=%b, expected 0 1", in_ready, out_valid);
      end
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || op_count !== cnt_before || err !== 1'b1) begin
         errors++;
         $display("FAIL flush_clear: got out_valid=%b op_count=%0d err=%b, expected 0 %0d 1",
                  out_valid, op_count, err, cnt_before);
      end
      out_ready = 1'b1;
      tick();
      tick();
      checks++;
      if (out_valid !== 1'b0 || op_count !== cnt_before) begin
         errors++;
         $display("FAIL flush_empty: got out_valid=%b op_count=%0d, expected 0 %0d", out_valid, op_count, cnt_before);
      end
   endtask

`ifdef SHIFT_ZFLAG_EN
   task automatic test_zflag();
      out_ready = 1'b1;
      send_op(4'b0100, 16'h8000, 4'd1, 4'd1);
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_z !== 1'b1) begin
         errors++;
         $display("FAIL zflag_outz1: got valid=%b out_z=%b, expected 1 1", out_valid, out_z);
      end
      tick();
      checks++;
      if (flag_z !== 1'b1) begin
         errors++;
         $display("FAIL zflag_flag1: got flag_z=%b, expected 1", flag_z);
      end
      send_op(4'b0100, 16'h0001, 4'd0, 4'd2);
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_z !== 1'b0 || out_data !== 16'h0001) begin
         errors++;
         $display("FAIL zflag_outz0: got valid=%b out_z=%b data=%h, expected 1 0 0001", out_valid, out_z, out_data);
      end
      tick();
      checks++;
      if (flag_z !== 1'b0) begin
         errors++;
         $display("FAIL zflag_flag0: got flag_z=%b, expected 0", flag_z);
      end
      drain();
   endtask
`endif

   task automatic test_saturation();
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         send_op(4'b0100, 16'(i + 1), 4'(i), 4'(i));
      end
      drain();
      checks++;
      if (op_count !== 4'hF || op_count !== 4'(model_cnt)) begin
         errors++;
         $display("FAIL sat_count: got op_count=%0d, expected 15 (model %0d)", op_count, model_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_sll_latency();
      test_sra();
      test_back_to_back();
      test_illegal();
      test_flush();
`ifdef SHIFT_ZFLAG_EN
      test_zflag();
`endif
      test_saturation();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
